sharp_stream_sink: RTL
======================

# sharp_stream_sink

Receive-side endpoint for the sharpening filter's output stream. Consumes the filter's signed, widened pixel stream, discards the pipeline-priming samples and clamps each pixel to 8-bit unsigned. Stores one N×N frame in an internal buffer, then replays it in raster order over a ready/valid interface to the frame writer. It replaces the simulation-only capture loop, so the sharpened image can be drained in hardware.

## Interface
- `N`, 128, frame width and height in pixels (square frame)
- `M`, 11, MSB index of the input pixel; input is M+1 bits, two's complement
- `SKIP`, 2, number of leading valid input samples discarded per frame (filter priming)
- `OW`, 8, output pixel width, unsigned

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse that arms capture of a new frame
- `in_valid`  in  1  qualifies `in_pix`
- `in_pix`  in  M+1  signed sharpened pixel from the filter
- `out_valid`  out  1  `out_pix`/`out_row`/`out_col`/`out_last` are valid
- `out_ready`  in  1  downstream accepts the current output pixel
- `out_pix`  out  OW  clamped pixel
- `out_row`  out  clog2(N)  row of `out_pix`
- `out_col`  out  clog2(N)  column of `out_pix`
- `out_last`  out  1  high with the final pixel (row N-1, col N-1)
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse after the last output handshake
- `sat_count`  out  16  count of clamped pixels in the current frame

## Operation
- States: IDLE, SKIP, CAPTURE, DRAIN, DONE.
- IDLE: `start` → SKIP (→ CAPTURE directly if SKIP=0). Clears the skip counter, write address and `sat_count`. `start` is ignored in every other state.
- SKIP: each `in_valid` cycle increments the skip counter and the data is dropped. After the SKIP-th valid sample → CAPTURE.
- CAPTURE: each `in_valid` cycle writes the clamped pixel to buffer address `wr_addr` (0..N*N-1, raster order) and increments `wr_addr`. The write at address N*N-1 → DRAIN.
- `in_valid` is ignored in IDLE, DRAIN and DONE. No back-pressure is applied to the filter.
- Clamp rule: `in_pix` < 0 → 0. `in_pix` > 2^OW-1 → 2^OW-1. Otherwise pass the low OW bits.
  - Each clamped sample increments `sat_count`.
  - `sat_count` saturates at 0xFFFF and does not wrap.
- DRAIN: reads the buffer at addresses 0..N*N-1 in order.
  - Row and column counters track the read address. Column wraps N-1→0 and increments the row.
  - `out_last` = (row==N-1 && col==N-1) && `out_valid`.
  - A handshake on `out_last` → DONE.
- DONE: `frame_done` = 1 for exactly one cycle, then → IDLE.
- Buffer: N*N × OW single-clock RAM with 1-cycle read latency. Contents are not cleared by reset.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE. `out_valid`, `out_pix`, `out_row`, `out_col`, `out_last`, `busy`, `frame_done` and `sat_count` are all 0. All counters are 0.
- Reset mid-frame aborts at once, with no `frame_done`. Reset has priority over `start`.
- `busy` rises the cycle after `start` is accepted and falls on the cycle the state returns to IDLE.
- First `out_valid` is asserted exactly 2 cycles after the cycle the last capture write occurs.
- While `out_valid`=1 and `out_ready`=0, all output signals hold stable.
- With `out_ready` held 1, output is one pixel per cycle with no bubbles. Read-ahead is required to hide the RAM latency.
- `out_valid` may not drop until its pixel has been accepted.
- `frame_done` is asserted the cycle after the `out_last` handshake. `out_valid` is 0 that cycle.
- Full N=128 frame, streaming input and `out_ready`=1: SKIP + 16384 input cycles, then output occupies cycles +2 .. +16385 after the last write.

## Test plan
- N=4, SKIP=2: `start`, then stream 18 valid samples: 99, 98, then 0..15. Required output sequence is 0..15 with row/col (0,0)…(3,3). `out_last` only on 15. `frame_done` pulses once. `sat_count`=0.
- Clamp: the capture samples include -5, 0, 255, 256, 2047 and -2048. Required outputs are 0, 0, 255, 255, 255, 0. `sat_count`=4.
- Gapped input and back-pressure:
  - `in_valid` toggles 1/0 during capture, and `out_ready` follows a random ~50% pattern.
  - Output order and values must match the capture order.
  - Outputs must hold stable during every stall.
  - Each pixel must be accepted exactly once.
- Reset mid-CAPTURE after 7 writes: every output is 0 the next cycle and `busy`=0. A fresh `start` plus a full frame yields correct output with no stale counts.
- `start` pulses during SKIP, CAPTURE and DRAIN are ignored: the frame completes normally and `frame_done` pulses once.
- N=128 full frame of a ramp (`in_pix` = index mod 300): 16384 outputs equal to min(index mod 300, 255). `sat_count` = number of indices whose value mod 300 is > 255.

Source files
------------

// File: rtl/sharp_stream_sink.sv
// Receive-side sink for the sharpening filter: drops priming samples, clamps to OW bits,
// buffers one NxN frame and replays it in raster order over ready/valid.
module sharp_stream_sink #(
   parameter int unsigned N    = 128,
   parameter int unsigned M    = 11,
   parameter int unsigned SKIP = 2,
   parameter int unsigned OW   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [M:0]             in_pix,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OW-1:0]          out_pix,
   output logic [$clog2(N)-1:0]   out_row,
   output logic [$clog2(N)-1:0]   out_col,
   output logic                   out_last,
   output logic                   busy,
   output logic                   frame_done,
   output logic [15:0]            sat_count
);

   localparam int unsigned Depth = N * N;
   localparam int unsigned AW    = $clog2(Depth);
   localparam int unsigned RW    = $clog2(N);
   localparam int unsigned SW    = (SKIP > 1) ? $clog2(SKIP + 1) : 1;

   typedef enum logic [2:0] {StIdle, StSkip, StCapture, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   skip_q, skip_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [AW:0]     rd_addr_q, rd_addr_d;
   logic [RW-1:0]   rd_row_q, rd_row_d;
   logic [RW-1:0]   rd_col_q, rd_col_d;
   logic [15:0]     sat_q, sat_d;
   logic            out_valid_q, out_valid_d;
   logic [OW-1:0]   out_pix_q;
   logic [RW-1:0]   out_row_q, out_col_q;

   logic            wr_en, rd_en;
   logic            neg, over, clamped;
   logic [OW-1:0]   clamp_pix;

   logic [OW-1:0]   mem [Depth];

   always_comb begin
      neg       = in_pix[M];
      over      = ~neg & (|in_pix[M-1:OW]);
      clamped   = neg | over;
      clamp_pix = neg ? '0 : (over ? '1 : in_pix[OW-1:0]);
   end

   assign out_last = out_valid_q && (out_row_q == RW'(N - 1)) && (out_col_q == RW'(N - 1));

   always_comb begin
      state_d    = state_q;
      skip_d     = skip_q;
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      rd_row_d   = rd_row_q;
      rd_col_d   = rd_col_q;
      sat_d      = sat_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      frame_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            rd_addr_d = '0;
            rd_row_d  = '0;
            rd_col_d  = '0;
            if (start) begin
               skip_d    = '0;
               wr_addr_d = '0;
               sat_d     = '0;
               state_d   = (SKIP == 0) ? StCapture : StSkip;
            end
         end
         StSkip: begin
            if (in_valid) begin
               skip_d = skip_q + 1'b1;
               if (skip_q == SW'(SKIP - 1)) state_d = StCapture;
            end
         end
         StCapture: begin
            if (in_valid) begin
               wr_en     = 1'b1;
               wr_addr_d = wr_addr_q + 1'b1;
               if (clamped && (sat_q != 16'hffff)) sat_d = sat_q + 16'd1;
               if (wr_addr_q == AW'(Depth - 1)) state_d = StDrain;
            end
         end
         StDrain: begin
            // Read ahead whenever the output register is empty or being emptied this cycle.
            rd_en = (rd_addr_q != (AW + 1)'(Depth)) && (!out_valid_q || out_ready);
            if (rd_en) begin
               rd_addr_d = rd_addr_q + 1'b1;
               if (rd_col_q == RW'(N - 1)) begin
                  rd_col_d = '0;
                  rd_row_d = rd_row_q + 1'b1;
               end else begin
                  rd_col_d = rd_col_q + 1'b1;
               end
            end
            if (out_last && out_ready) state_d = StDone;
         end
         StDone: begin
            frame_done = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase

      out_valid_d = rd_en | (out_valid_q & ~out_ready);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         skip_q      <= '0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         rd_row_q    <= '0;
         rd_col_q    <= '0;
         sat_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         rd_row_q    <= rd_row_d;
         rd_col_q    <= rd_col_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Frame buffer: contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr_q] <= clamp_pix;
   end

   // RAM read register doubles as the output register; it only advances on a read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_pix_q <= '0;
         out_row_q <= '0;
         out_col_q <= '0;
      end else if (rd_en) begin
         out_pix_q <= mem[rd_addr_q[AW-1:0]];
         out_row_q <= rd_row_q;
         out_col_q <= rd_col_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign busy      = (state_q != StIdle);
   assign sat_count = sat_q;

endmodule
